// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   Multi-channel down-counting timer peripheral for the SoC peripheral bus.
//   Each channel counts down once per shared prescaler tick. It can run as a
//   one-shot timer or as a periodic timer. Each channel records a sticky
//   event flag in PEND, and each flag can be masked before it reaches irq.
//
//   Word address map:
//     4c+0 CTRL  {IE, RELOAD, EN}      (channel c < NCH)
//     4c+1 LOAD  reload value; a write also loads COUNT
//     4c+2 COUNT current value, read-only
//     4c+3 reserved, reads 0
//     32   PEND  sticky event flags, write-1-to-clear
//     33   PRESC prescaler compare value
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   sel    peripheral selected this cycle
//   we     write strobe, only valid when sel is high
//   addr   word address within the peripheral
//   din    write data
//   dout   registered read data (one-cycle latency, 0 when no read)
//   irq    registered level interrupt, |(PEND & IE)
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int XLEN = 32,
    parameter int NCH  = 4,
    parameter int PSW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sel,
    input  logic            we,
    input  logic [5:0]      addr,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            irq
);

    localparam logic [5:0] ADDR_PEND  = 6'd32;
    localparam logic [5:0] ADDR_PRESC = 6'd33;

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_LOAD  = 2'd1,
        REG_COUNT = 2'd2,
        REG_RSVD  = 2'd3
    } ch_reg_e;

    // Register state
    logic [NCH-1:0]  en_q, en_d;
    logic [NCH-1:0]  reload_q, reload_d;
    logic [NCH-1:0]  ie_q, ie_d;
    logic [NCH-1:0]  pend_q, pend_d;
    logic [XLEN-1:0] load_q  [NCH];
    logic [XLEN-1:0] load_d  [NCH];
    logic [XLEN-1:0] count_q [NCH];
    logic [XLEN-1:0] count_d [NCH];
    logic [PSW-1:0]  presc_q, presc_d;
    logic [PSW-1:0]  pcnt_q, pcnt_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic            irq_q, irq_d;

    // Decode
    logic            wr;
    logic            presc_wr;
    logic            pend_wr;
    logic            tick;
    logic [NCH-1:0]  ch_wr;
    logic [NCH-1:0]  event_hit;
    logic [XLEN-1:0] rd_val;
    ch_reg_e         ch_reg;

    assign wr       = sel && we;
    assign presc_wr = wr && (addr == ADDR_PRESC);
    assign pend_wr  = wr && (addr == ADDR_PEND);
    assign ch_reg   = ch_reg_e'(addr[1:0]);

    // Channel write decode. Words 0..31 form the channel area. Channels at or
    // above NCH never match, so writes to them are dropped.
    always_comb begin
        ch_wr = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_wr[c] = wr && !addr[5] && (addr[4:2] == 3'(c));
        end
    end

    // Prescaler. pcnt runs from 0 to PRESC and then wraps. The wrap cycle is
    // the tick. A PRESC write restarts the count and swallows that cycle's tick.
    always_comb begin
        presc_d = presc_wr ? din[PSW-1:0] : presc_q;
        tick    = (pcnt_q == presc_q) && !presc_wr;
        if (presc_wr || (pcnt_q == presc_q)) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PSW'(1);
        end
    end

    // Channel state. A bus write to a channel takes priority over that
    // channel's tick processing in the same cycle.
    // NOTE: every output of this block gets its default before any branch, so
    // paths that leave a signal unassigned cannot infer a latch.
    always_comb begin
        en_d      = en_q;
        reload_d  = reload_q;
        ie_d      = ie_q;
        load_d    = load_q;
        count_d   = count_q;
        event_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_wr[c]) begin
                case (ch_reg)
                    REG_CTRL: begin
                        en_d[c]     = din[0];
                        reload_d[c] = din[1];
                        ie_d[c]     = din[2];
                    end
                    REG_LOAD: begin
                        load_d[c]  = din;
                        count_d[c] = din;
                    end
                    default: ;  // COUNT is read-only; the reserved word has no storage
                endcase
            end else if (tick && en_q[c]) begin
                if (count_q[c] != '0) begin
                    count_d[c] = count_q[c] - XLEN'(1);
                end else begin
                    // Expiry: flag the event, then reload or stop at zero.
                    event_hit[c] = 1'b1;
                    if (reload_q[c]) begin
                        count_d[c] = load_q[c];
                    end else begin
                        en_d[c] = 1'b0;
                    end
                end
            end
        end
    end

    // Sticky pending flags. The clear is applied before the new events are
    // merged in, so an event in the same cycle keeps its bit set.
    always_comb begin
        pend_d = pend_q;
        if (pend_wr) begin
            pend_d = pend_q & ~din[NCH-1:0];
        end
        pend_d = pend_d | event_hit;
    end

    // Read mux and interrupt
    always_comb begin
        rd_val = '0;
        if (!addr[5]) begin
            for (int c = 0; c < NCH; c++) begin
                if (addr[4:2] == 3'(c)) begin
                    case (ch_reg)
                        REG_CTRL:  rd_val[2:0] = {ie_q[c], reload_q[c], en_q[c]};
                        REG_LOAD:  rd_val      = load_q[c];
                        REG_COUNT: rd_val      = count_q[c];
                        default:   rd_val      = '0;
                    endcase
                end
            end
        end else if (addr == ADDR_PEND) begin
            rd_val[NCH-1:0] = pend_q;
        end else if (addr == ADDR_PRESC) begin
            rd_val[PSW-1:0] = presc_q;
        end

        dout_d = (sel && !we) ? rd_val : '0;
        irq_d  = |(pend_q & ie_q);
    end

    // State registers
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of the other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= '0;
            reload_q <= '0;
            ie_q     <= '0;
            pend_q   <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            dout_q   <= '0;
            irq_q    <= 1'b0;
            // NOTE: LOAD/COUNT are small register arrays that software can see,
            // so they are reset like any other flop. They are not memories.
            for (int c = 0; c < NCH; c++) begin
                load_q[c]  <= '0;
                count_q[c] <= '0;
            end
        end else begin
            en_q     <= en_d;
            reload_q <= reload_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            dout_q   <= dout_d;
            irq_q    <= irq_d;
            for (int c = 0; c < NCH; c++) begin
                load_q[c]  <= load_d[c];
                count_q[c] <= count_d[c];
            end
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//   Directed testbench for timer_bank. A behavioural model of the register
//   file is updated once per clock from the same bus inputs that the DUT
//   sees. A compare process checks dout and irq against the model on every
//   falling edge. Hand-computed literal expectations at key points pin the
//   model.
// -----------------------------------------------------------------------------
module tb_timer_bank;

    localparam int XLEN = 32;
    localparam int NCH  = 4;
    localparam int PSW  = 8;

    logic            clk;
    logic            rst_n;
    logic            sel;
    logic            we;
    logic [5:0]      addr;
    logic [XLEN-1:0] din;
    logic [XLEN-1:0] dout;
    logic            irq;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    timer_bank #(.XLEN(XLEN), .NCH(NCH), .PSW(PSW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    logic [31:0]    m_load  [NCH];
    logic [31:0]    m_count [NCH];
    bit             m_en    [NCH];
    bit             m_rel   [NCH];
    bit             m_ie    [NCH];
    logic [NCH-1:0] m_pend;
    int unsigned    m_presc;
    int unsigned    m_since;   // cycles since the prescaler was last restarted
    logic [31:0]    m_dout;
    logic           m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_load[c]  = '0;
            m_count[c] = '0;
            m_en[c]    = 1'b0;
            m_rel[c]   = 1'b0;
            m_ie[c]    = 1'b0;
        end
        m_pend  = '0;
        m_presc = 0;
        m_since = 0;
        m_dout  = '0;
        m_irq   = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        int c;
        v = '0;
        c = a / 4;
        if (a < 32) begin
            if (c < NCH) begin
                case (a % 4)
                    0:       v = {29'd0, m_ie[c], m_rel[c], m_en[c]};
                    1:       v = m_load[c];
                    2:       v = m_count[c];
                    default: v = '0;
                endcase
            end
        end else if (a == 32) begin
            v = {{(32-NCH){1'b0}}, m_pend};
        end else if (a == 33) begin
            v = m_presc;
        end
        return v;
    endfunction

    // Advances the model by one clock edge for the given pre-edge bus inputs.
    task automatic model_update(input logic s, input logic w, input logic [5:0] a,
                                input logic [31:0] d);
        int             ai;
        bit             wr_cyc;
        bit             presc_wr;
        bit             tick;
        logic [NCH-1:0] ev;
        ai       = int'(a);
        wr_cyc   = s && w;
        presc_wr = wr_cyc && (ai == 33);
        ev       = '0;

        // The outputs are registered, so they reflect the state before this edge.
        m_dout = (s && !w) ? model_read(ai) : 32'd0;
        m_irq  = |(m_pend & ie_vec());

        // A tick fires on the last cycle of every block of PRESC+1 cycles after a restart.
        tick    = !presc_wr && (((m_since + 1) % (m_presc + 1)) == 0);
        m_since = presc_wr ? 0 : m_since + 1;

        for (int c = 0; c < NCH; c++) begin
            if (wr_cyc && ai < 32 && (ai / 4) == c) begin
                if (ai % 4 == 0) begin
                    m_en[c]  = d[0];
                    m_rel[c] = d[1];
                    m_ie[c]  = d[2];
                end else if (ai % 4 == 1) begin
                    m_load[c]  = d;
                    m_count[c] = d;
                end
            end else if (tick && m_en[c]) begin
                if (m_count[c] > 0) begin
                    m_count[c] = m_count[c] - 1;
                end else begin
                    ev[c] = 1'b1;
                    if (m_rel[c]) m_count[c] = m_load[c];
                    else          m_en[c]    = 1'b0;
                end
            end
        end

        if (wr_cyc && ai == 32) m_pend = m_pend & ~d[NCH-1:0];
        m_pend = m_pend | ev;
        if (presc_wr) m_presc = {24'd0, d[7:0]};
    endtask

    function automatic logic [NCH-1:0] ie_vec();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_ie[c];
        return v;
    endfunction

    // ------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_dout", dout, m_dout);
            check("cmp_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // ------------------------------------------------------------- stimulus
    // Inputs are applied on the falling edge. The model advances on the
    // rising edge. The task returns on the next falling edge with outputs settled.
    task automatic step(input logic s, input logic w, input logic [5:0] a, input logic [31:0] d);
        sel  = s;
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update(s, w, a, d);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        step(1'b1, 1'b1, 6'(a), d);
    endtask

    task automatic rd(input int a);
        step(1'b1, 1'b0, 6'(a), 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    initial begin
        // NOTE: bench inputs are driven with blocking assignments away from the
        // rising edge, so the DUT always samples stable values.
        rst_n = 1'b0;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        model_reset();
        @(negedge clk);
        idle();
        idle();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        check("rst_dout", dout, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // 1: basic read path, unmapped space, read-only COUNT
        wr(1, 32'd5);
        rd(1);          check("t1_rd_load0", dout, 32'd5);
        idle();         check("t1_dout_idle", dout, 32'd0);
        rd(40);         check("t1_rd_unmapped", dout, 32'd0);
        wr(17, 32'h55); // LOAD of channel 4 is out of range for NCH=4
        rd(17);         check("t1_rd_ch4", dout, 32'd0);
        wr(2, 32'd77);  // COUNT write is ignored
        rd(2);          check("t1_rd_count0", dout, 32'd5);

        // 2: one-shot with a tick on every cycle
        wr(1, 32'd3);
        wr(0, 32'd5);
        rd(2);          check("t2_count3", dout, 32'd3);
        rd(2);          check("t2_count2", dout, 32'd2);
        rd(2);          check("t2_count1", dout, 32'd1);
        rd(2);          check("t2_count0", dout, 32'd0);
                        check("t2_irq_pre", {31'd0, irq}, 32'd0);
        rd(32);         check("t2_pend", dout, 32'd1);
                        check("t2_irq", {31'd0, irq}, 32'd1);
        rd(0);          check("t2_ctrl_en_off", dout, 32'd4);
        rd(2);          check("t2_count_stays0", dout, 32'd0);
        wr(32, 32'd1);
        wr(0, 32'd0);

        // 3: periodic on channel 1 with PRESC=2 (period 6 cycles)
        wr(33, 32'd2);
        wr(5, 32'd1);
        wr(4, 32'd7);
        idle(); idle(); idle();
        idle();         check("t3_irq_before_ev", {31'd0, irq}, 32'd0);
        rd(32);         check("t3_pend_ev1", dout, 32'd2);
                        check("t3_irq_ev1", {31'd0, irq}, 32'd1);
        wr(32, 32'd2);
        idle();         check("t3_irq_cleared", {31'd0, irq}, 32'd0);
        idle(); idle();
        idle();         check("t3_irq_at_ev2", {31'd0, irq}, 32'd0);
        idle();         check("t3_irq_ev2", {31'd0, irq}, 32'd1);
        wr(4, 32'd0);
        wr(32, 32'hF);
        rd(33);         check("t3_rd_presc", dout, 32'd2);
        wr(33, 32'd0);

        // 4a: PEND clear in the same cycle as channel 0's expiry
        wr(1, 32'd2);
        wr(0, 32'd3);
        idle();
        idle();
        wr(32, 32'd1);
        rd(32);         check("t4_pend_event_wins", dout, 32'd1);
        // 4b: LOAD write during a tick cycle
        wr(1, 32'd9);
        rd(2);          check("t4_count_written", dout, 32'd9);
        rd(2);          check("t4_count_dec", dout, 32'd8);
        wr(0, 32'd0);
        wr(32, 32'hF);

        // 5: two channels expiring every tick, only channel 2 unmasked
        wr(1, 32'd0);
        wr(0, 32'd3);
        wr(9, 32'd0);
        wr(8, 32'd7);
        idle();
        rd(32);         check("t5_pend", dout, 32'd5);
                        check("t5_irq", {31'd0, irq}, 32'd1);
        wr(8, 32'd3);
        idle();
        rd(32);         check("t5_pend_kept", dout, 32'd5);
                        check("t5_irq_masked", {31'd0, irq}, 32'd0);

        // 6: asynchronous reset between clock edges
        wr(8, 32'd7);
        idle();
        rd(32);         check("t6_dout_pre", dout, 32'd5);
                        check("t6_irq_pre", {31'd0, irq}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_dout_async", dout, 32'd0);
        check("t6_irq_async", {31'd0, irq}, 32'd0);
        check("t6_count_async", dut.count_q[0], 32'd0);
        model_reset();
        idle();
        idle();
        rst_n = 1'b1;
        for (int a = 0; a < 34; a++) begin
            rd(a);
            check("t6_rd_after_reset", dout, 32'd0);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
